// File: rtl/ddc_tune_ctrl.sv
// rtl/ddc_tune_ctrl.sv - run/retune sequencer in front of one ddc instance
// Holds the ddc config, flushes and settles the ddc on start/retune, then gates its output.
module ddc_tune_ctrl #(
  parameter int IQ_NUM         = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 14,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         enable_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [PHASE_WIDTH-1:0]       cfg_phase_inc_i,
  input  logic [PHASE_WIDTH-1:0]       cfg_phase_offset_i,
  input  logic [DATA_WIDTH-1:0]        cfg_decimation_i,
  input  logic                         cfg_round_type_i,
  output logic                         ddc_rst_o,
  output logic                         ddc_en_o,
  output logic [PHASE_WIDTH-1:0]       ddc_phase_inc_o,
  output logic [PHASE_WIDTH-1:0]       ddc_phase_offset_o,
  output logic [DATA_WIDTH-1:0]        ddc_decimation_o,
  output logic                         ddc_round_type_o,
  input  logic                         ddc_tvalid_i,
  input  logic [IQ_NUM*DATA_WIDTH-1:0] ddc_tdata_i,
  output logic                         tvalid_o,
  output logic [IQ_NUM*DATA_WIDTH-1:0] tdata_o,
  output logic                         locked_o,
  output logic [CNT_WIDTH-1:0]         retune_cnt_o
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_SAMPLES > 0) ? SW'(SETTLE_SAMPLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t                        state_q, state_d;
  logic [FW-1:0]                 flush_q, flush_d;
  logic [SW-1:0]                 settle_q, settle_d;
  logic [PHASE_WIDTH-1:0]        phase_inc_q, phase_inc_d;
  logic [PHASE_WIDTH-1:0]        phase_offset_q, phase_offset_d;
  logic [DATA_WIDTH-1:0]         decimation_q, decimation_d;
  logic                          round_type_q, round_type_d;
  logic [CNT_WIDTH-1:0]          retune_q, retune_d;
  logic                          tvalid_q, tvalid_d;
  logic [IQ_NUM*DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                          locked_q, locked_d;
  logic                          ddc_rst_q, ddc_rst_d;
  logic                          ddc_en_q, ddc_en_d;
  logic                          accept;
  logic                          run_stay;

  assign cfg_ready_o = (state_q == S_IDLE) || ((state_q == S_RUN) && enable_i);
  assign accept      = cfg_valid_i && cfg_ready_o;

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!enable_i)                state_d = S_IDLE;
        else if (flush_q == FW'(1))   state_d = S_SETTLE;
        else                          flush_d = flush_q - FW'(1);
      end
      S_SETTLE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (SETTLE_SAMPLES == 0) begin
          state_d = S_RUN;
        end else if (ddc_tvalid_i) begin
          // The pulse that completes the settle count is itself dropped.
          if (settle_q == SETTLE_LAST) state_d  = S_RUN;
          else                         settle_d = settle_q + SW'(1);
        end
      end
      S_RUN: begin
        if (!enable_i)   state_d = S_IDLE;
        else if (accept) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_FLUSH) && (state_q != S_FLUSH))   flush_d  = FW'(FLUSH_CYCLES);
    if ((state_d == S_SETTLE) && (state_q != S_SETTLE)) settle_d = '0;
  end

  always_comb begin
    phase_inc_d    = phase_inc_q;
    phase_offset_d = phase_offset_q;
    decimation_d   = decimation_q;
    round_type_d   = round_type_q;
    retune_d       = retune_q;
    if (accept) begin
      phase_inc_d    = cfg_phase_inc_i;
      phase_offset_d = cfg_phase_offset_i;
      decimation_d   = (cfg_decimation_i == '0) ? DATA_WIDTH'(1) : cfg_decimation_i;
      round_type_d   = cfg_round_type_i;
      if (state_q == S_RUN) retune_d = retune_q + CNT_WIDTH'(1);
    end
  end

  // Output is only forwarded while RUN persists across the edge.
  assign run_stay = (state_q == S_RUN) && (state_d == S_RUN);

  always_comb begin
    tvalid_d  = run_stay && ddc_tvalid_i;
    tdata_d   = (run_stay && ddc_tvalid_i) ? ddc_tdata_i : tdata_q;
    locked_d  = (state_d == S_RUN);
    ddc_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    ddc_en_d  = (state_d == S_SETTLE) || (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= S_IDLE;
      flush_q        <= '0;
      settle_q       <= '0;
      phase_inc_q    <= '0;
      phase_offset_q <= '0;
      decimation_q   <= DATA_WIDTH'(1);
      round_type_q   <= 1'b0;
      retune_q       <= '0;
      tvalid_q       <= 1'b0;
      tdata_q        <= '0;
      locked_q       <= 1'b0;
      ddc_rst_q      <= 1'b1;
      ddc_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      settle_q       <= settle_d;
      phase_inc_q    <= phase_inc_d;
      phase_offset_q <= phase_offset_d;
      decimation_q   <= decimation_d;
      round_type_q   <= round_type_d;
      retune_q       <= retune_d;
      tvalid_q       <= tvalid_d;
      tdata_q        <= tdata_d;
      locked_q       <= locked_d;
      ddc_rst_q      <= ddc_rst_d;
      ddc_en_q       <= ddc_en_d;
    end
  end

  assign ddc_rst_o          = ddc_rst_q;
  assign ddc_en_o           = ddc_en_q;
  assign ddc_phase_inc_o    = phase_inc_q;
  assign ddc_phase_offset_o = phase_offset_q;
  assign ddc_decimation_o   = decimation_q;
  assign ddc_round_type_o   = round_type_q;
  assign tvalid_o           = tvalid_q;
  assign tdata_o            = tdata_q;
  assign locked_o           = locked_q;
  assign retune_cnt_o       = retune_q;

endmodule
